// File: rtl/param_updown_counter_pkg.sv
// Shared encodings for the parametrised up/down counter.
// Mode and direction constants used by the top level and the next-count logic.
package param_updown_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the parametrised up/down counter.
// master: drives en/load/data/up_down/step/limit/sat_mode/clr_flags; slave: drives out/tc/ovf/unf/at_max/at_min.
interface param_updown_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);

    logic              en;
    logic              load;
    logic [WIDTH-1:0]  data;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              sat_mode;
    logic              clr_flags;
    logic [WIDTH-1:0]  out;
    logic              tc;
    logic              ovf;
    logic              unf;
    logic              at_max;
    logic              at_min;

    modport master (
        output en, load, data, up_down, step, limit, sat_mode, clr_flags,
        input  out, tc, ovf, unf, at_max, at_min
    );

    modport slave (
        input  en, load, data, up_down, step, limit, sat_mode, clr_flags,
        output out, tc, ovf, unf, at_max, at_min
    );

endinterface

// File: rtl/param_updown_counter_updn_next_calc.sv
// Combinational next-count logic: one step of size s within 0..limit.
// Ports: count, s, limit, up_down, sat_mode in; next_count, ovf_evt, unf_evt out.
module updn_next_calc
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_down,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] next_count,
    output logic             ovf_evt,
    output logic             unf_evt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;

    // Extra bit on sum keeps the carry for the compare against limit.
    assign sum = {1'b0, count} + {1'b0, s};

    // True results lie in 0..limit, so modulo-2^WIDTH arithmetic is exact.
    assign wrap_up = count + s - limit - WIDTH'(1);
    assign wrap_dn = count - s + limit + WIDTH'(1);

    always_comb begin
        next_count = count;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (count > limit) begin
            // Limit shrank below the count: re-enter range silently.
            next_count = (up_down == DIR_UP) ? '0 : limit;
        end else if (up_down == DIR_UP) begin
            if (sum <= {1'b0, limit}) begin
                next_count = sum[WIDTH-1:0];
            end else begin
                ovf_evt    = 1'b1;
                next_count = (sat_mode == MODE_SAT) ? limit : wrap_up;
            end
        end else begin
            if (count >= s) begin
                next_count = count - s;
            end else begin
                unf_evt    = 1'b1;
                next_count = (sat_mode == MODE_SAT) ? '0 : wrap_dn;
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with limit, step, load, wrap/saturate, tc and sticky flags.
// Ports: clk, reset (async active-low), bus (slave side of param_updown_counter_if).
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    param_updown_counter_if.slave  bus
);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    logic             unf_q;
    logic [WIDTH-1:0] step_ext;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] next_count;
    logic             ovf_evt;
    logic             unf_evt;
    logic             counting;

    assign step_ext = WIDTH'(bus.step);
    assign s        = (step_ext > bus.limit) ? bus.limit : step_ext;
    assign load_val = (bus.data > bus.limit) ? bus.limit : bus.data;
    assign counting = bus.en & ~bus.load;

    updn_next_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .count      (count_q),
        .s          (s),
        .limit      (bus.limit),
        .up_down    (bus.up_down),
        .sat_mode   (bus.sat_mode),
        .next_count (next_count),
        .ovf_evt    (ovf_evt),
        .unf_evt    (unf_evt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.load) begin
                count_q <= load_val;
                tc_q    <= 1'b0;
            end else if (bus.en) begin
                count_q <= next_count;
                tc_q    <= ovf_evt | unf_evt;
            end else begin
                tc_q    <= 1'b0;
            end
            // A new event outranks a clear in the same cycle.
            ovf_q <= (ovf_q & ~bus.clr_flags) | (counting & ovf_evt);
            unf_q <= (unf_q & ~bus.clr_flags) | (counting & unf_evt);
        end
    end

    assign bus.out    = count_q;
    assign bus.tc     = tc_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
    assign bus.at_max = (count_q == bus.limit);
    assign bus.at_min = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed testbench for param_updown_counter.
// One task per scenario, inline comparisons, single summary line.
module tb_param_updown_counter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    param_updown_counter_if #(.WIDTH(8), .STEP_W(4)) bus ();

    param_updown_counter #(
        .WIDTH  (8),
        .STEP_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v, input logic [7:0] lim);
        bus.limit     = lim;
        bus.data      = v;
        bus.load      = 1'b1;
        bus.en        = 1'b0;
        bus.clr_flags = 1'b1;
        tick();
        bus.load      = 1'b0;
        bus.clr_flags = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.out !== 8'd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", bus.out); end
        checks++; if ({bus.tc, bus.ovf, bus.unf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.tc, bus.ovf, bus.unf}); end
        checks++; if (bus.at_min !== 1'b1) begin failures++; $display("FAIL reset_at_min got=%b exp=1", bus.at_min); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_count;
        do_load(8'd3, 8'd3);
        bus.step     = 4'd1;
        bus.up_down  = 1'b1;
        bus.sat_mode = 1'b0;
        bus.en       = 1'b1;
        tick();
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL rmc_pre_ovf got=%b exp=1", bus.ovf); end
        do_load(8'd0, 8'd255);
        bus.en = 1'b1;
        repeat (5) tick();
        checks++; if (bus.out !== 8'd5) begin failures++; $display("FAIL rmc_count5 got=%0d exp=5", bus.out); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.out !== 8'd0) begin failures++; $display("FAIL rmc_async_out got=%0d exp=0", bus.out); end
        checks++; if ({bus.tc, bus.ovf, bus.unf} !== 3'b000) begin failures++; $display("FAIL rmc_async_flags got=%b exp=000", {bus.tc, bus.ovf, bus.unf}); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (bus.out !== 8'd1) begin failures++; $display("FAIL rmc_release got=%0d exp=1", bus.out); end
        bus.en = 1'b0;
    endtask

    task automatic test_wrap_up;
        do_load(8'd8, 8'd9);
        bus.step     = 4'd3;
        bus.sat_mode = 1'b0;
        bus.up_down  = 1'b1;
        bus.en       = 1'b1;
        tick();
        checks++; if (bus.out !== 8'd1) begin failures++; $display("FAIL wrap_out got=%0d exp=1", bus.out); end
        checks++; if ({bus.tc, bus.ovf, bus.unf} !== 3'b110) begin failures++; $display("FAIL wrap_flags got=%b exp=110", {bus.tc, bus.ovf, bus.unf}); end
        bus.en = 1'b0;
        tick();
        checks++; if ({bus.tc, bus.ovf} !== 2'b01) begin failures++; $display("FAIL wrap_tc_pulse got=%b exp=01", {bus.tc, bus.ovf}); end
        checks++; if (bus.out !== 8'd1) begin failures++; $display("FAIL hold_out got=%0d exp=1", bus.out); end
    endtask

    task automatic test_sat_down;
        do_load(8'd2, 8'd200);
        bus.sat_mode = 1'b1;
        bus.step     = 4'd5;
        bus.up_down  = 1'b0;
        bus.en       = 1'b1;
        tick();
        checks++; if (bus.out !== 8'd0) begin failures++; $display("FAIL satdn_out got=%0d exp=0", bus.out); end
        checks++; if ({bus.tc, bus.ovf, bus.unf} !== 3'b101) begin failures++; $display("FAIL satdn_flags got=%b exp=101", {bus.tc, bus.ovf, bus.unf}); end
        tick();
        checks++; if ({bus.out, bus.tc} !== {8'd0, 1'b1}) begin failures++; $display("FAIL satdn_again got=%0d/%b exp=0/1", bus.out, bus.tc); end
    endtask

    task automatic test_load_clamp;
        bus.limit = 8'd50;
        bus.data  = 8'd80;
        bus.load  = 1'b1;
        bus.en    = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.en   = 1'b0;
        checks++; if (bus.out !== 8'd50) begin failures++; $display("FAIL load_clamp_out got=%0d exp=50", bus.out); end
        checks++; if (bus.tc !== 1'b0) begin failures++; $display("FAIL load_tc got=%b exp=0", bus.tc); end
        checks++; if (bus.at_max !== 1'b1) begin failures++; $display("FAIL load_at_max got=%b exp=1", bus.at_max); end
    endtask

    task automatic test_limit_shrink;
        bus.sat_mode = 1'b0;
        bus.step     = 4'd1;
        do_load(8'd40, 8'd50);
        bus.limit   = 8'd30;
        bus.up_down = 1'b1;
        bus.en      = 1'b1;
        tick();
        checks++; if (bus.out !== 8'd0) begin failures++; $display("FAIL shrink_up_out got=%0d exp=0", bus.out); end
        checks++; if ({bus.tc, bus.ovf, bus.unf} !== 3'b000) begin failures++; $display("FAIL shrink_up_flags got=%b exp=000", {bus.tc, bus.ovf, bus.unf}); end
        do_load(8'd40, 8'd50);
        bus.limit   = 8'd30;
        bus.up_down = 1'b0;
        bus.en      = 1'b1;
        tick();
        bus.en = 1'b0;
        checks++; if (bus.out !== 8'd30) begin failures++; $display("FAIL shrink_dn_out got=%0d exp=30", bus.out); end
        checks++; if ({bus.tc, bus.unf} !== 2'b00) begin failures++; $display("FAIL shrink_dn_flags got=%b exp=00", {bus.tc, bus.unf}); end
    endtask

    task automatic test_flag_race;
        do_load(8'd8, 8'd9);
        bus.step     = 4'd3;
        bus.sat_mode = 1'b0;
        bus.up_down  = 1'b1;
        bus.en       = 1'b1;
        tick();
        tick();
        tick();
        checks++; if ({bus.out, bus.ovf} !== {8'd7, 1'b1}) begin failures++; $display("FAIL race_pre got=%0d/%b exp=7/1", bus.out, bus.ovf); end
        bus.clr_flags = 1'b1;
        tick();
        checks++; if ({bus.out, bus.tc, bus.ovf} !== {8'd0, 2'b11}) begin failures++; $display("FAIL race_set_wins got=%0d/%b/%b exp=0/1/1", bus.out, bus.tc, bus.ovf); end
        bus.en = 1'b0;
        tick();
        bus.clr_flags = 1'b0;
        checks++; if ({bus.tc, bus.ovf} !== 2'b00) begin failures++; $display("FAIL race_clear got=%b exp=00", {bus.tc, bus.ovf}); end
    endtask

    task automatic test_back_to_back;
        do_load(8'd20, 8'd20);
        bus.sat_mode = 1'b1;
        bus.step     = 4'd2;
        bus.up_down  = 1'b1;
        bus.en       = 1'b1;
        tick();
        checks++; if ({bus.out, bus.tc, bus.ovf} !== {8'd20, 2'b11}) begin failures++; $display("FAIL b2b_sat1 got=%0d/%b/%b exp=20/1/1", bus.out, bus.tc, bus.ovf); end
        tick();
        checks++; if ({bus.out, bus.tc} !== {8'd20, 1'b1}) begin failures++; $display("FAIL b2b_sat2 got=%0d/%b exp=20/1", bus.out, bus.tc); end
        do_load(8'd1, 8'd9);
        bus.sat_mode = 1'b0;
        bus.step     = 4'd4;
        bus.up_down  = 1'b0;
        bus.en       = 1'b1;
        tick();
        checks++; if ({bus.out, bus.tc, bus.unf} !== {8'd7, 2'b11}) begin failures++; $display("FAIL dnwrap1 got=%0d/%b/%b exp=7/1/1", bus.out, bus.tc, bus.unf); end
        tick();
        checks++; if ({bus.out, bus.tc} !== {8'd3, 1'b0}) begin failures++; $display("FAIL dnwrap2 got=%0d/%b exp=3/0", bus.out, bus.tc); end
        tick();
        checks++; if ({bus.out, bus.tc} !== {8'd9, 1'b1}) begin failures++; $display("FAIL dnwrap3 got=%0d/%b exp=9/1", bus.out, bus.tc); end
        bus.en = 1'b0;
    endtask

    task automatic test_step_edges;
        do_load(8'd0, 8'd5);
        bus.sat_mode = 1'b0;
        bus.step     = 4'd15;
        bus.up_down  = 1'b1;
        bus.en       = 1'b1;
        tick();
        checks++; if ({bus.out, bus.tc} !== {8'd5, 1'b0}) begin failures++; $display("FAIL clamp1 got=%0d/%b exp=5/0", bus.out, bus.tc); end
        tick();
        checks++; if ({bus.out, bus.tc} !== {8'd4, 1'b1}) begin failures++; $display("FAIL clamp2 got=%0d/%b exp=4/1", bus.out, bus.tc); end
        bus.step = 4'd0;
        tick();
        checks++; if ({bus.out, bus.tc} !== {8'd4, 1'b0}) begin failures++; $display("FAIL step0 got=%0d/%b exp=4/0", bus.out, bus.tc); end
        bus.limit = 8'd0;
        bus.step  = 4'd3;
        tick();
        tick();
        checks++; if ({bus.out, bus.tc, bus.at_max} !== {8'd0, 2'b01}) begin failures++; $display("FAIL lim0 got=%0d/%b/%b exp=0/0/1", bus.out, bus.tc, bus.at_max); end
        bus.en = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.en        = 1'b0;
        bus.load      = 1'b0;
        bus.data      = 8'd0;
        bus.up_down   = 1'b1;
        bus.step      = 4'd1;
        bus.limit     = 8'd255;
        bus.sat_mode  = 1'b0;
        bus.clr_flags = 1'b0;
        test_reset();
        test_reset_mid_count();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_limit_shrink();
        test_flag_race();
        test_back_to_back();
        test_step_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the 8-bit up/down counter.
- Adds the following over the fixed 8-bit part:
  - configurable width
  - programmable modulus limit
  - variable step
  - synchronous parallel load
  - count enable
  - wrap or saturate mode
  - terminal-count pulse and sticky overflow/underflow flags
- Used as the general event, position and address counter in the datapath. Software or an FSM loads it, steps it and watches its flags.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- STEP_W, 4, width of the step input (legal range 1..WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to clk.
- en  in  1  count enable. Counting happens only when en=1 and load=0.
- load  in  1  synchronous load of data. Has priority over en.
- data  in  WIDTH  load value.
- up_down  in  1  1 = count up, 0 = count down.
- step  in  STEP_W  increment/decrement magnitude.
- limit  in  WIDTH  upper bound of the count range; the legal range is 0..limit.
- sat_mode  in  1  0 = wrap modulo (limit+1), 1 = saturate at 0/limit.
- clr_flags  in  1  synchronous clear of ovf and unf.
- out  out  WIDTH  current count (registered).
- tc  out  1  one-cycle pulse, registered. Fires on the cycle after a wrap or saturation clip.
- ovf  out  1  sticky flag: an upward wrap/clip has occurred.
- unf  out  1  sticky flag: a downward wrap/clip has occurred.
- at_max  out  1  combinational, (out == limit).
- at_min  out  1  combinational, (out == 0).

Behaviour:
- Reset (reset=0):
  - out=0, tc=0, ovf=0, unf=0, applied immediately (asynchronous).
  - A reset asserted in the middle of a count abandons the update; the first edge after release behaves normally.
- Priority per clock edge: load > en > hold.
  - load=1: out <= min(data, limit). tc=0 that cycle. No flag update.
  - en=0 and load=0: out holds, tc <= 0.
- Effective step: s = min(step, limit), zero-extended. step=0 means hold with no event. limit=0 pins out to 0.
- Arithmetic is done at WIDTH+1 bits to catch carry and borrow.
- Out-of-range count (limit reduced below out at runtime):
  - Next enabled count forces out to 0 when counting up, or to limit when counting down.
  - No tc, no flag.
- Up, in range:
  - If out+s <= limit: out <= out+s.
  - Otherwise it is an overflow event:
    - wrap mode: out <= out+s-(limit+1)
    - saturate mode: out <= limit
    - In both modes: tc <= 1, ovf <= 1.
  - In saturate mode, counting up while already at limit is an event (tc pulses every cycle).
- Down, in range:
  - If out >= s: out <= out-s.
  - Otherwise it is an underflow event:
    - wrap mode: out <= out-s+limit+1
    - saturate mode: out <= 0
    - In both modes: tc <= 1, unf <= 1.
- Because s <= limit, one correction always lands in 0..limit.
- tc is high for exactly one cycle per event. Back-to-back events keep it high on consecutive cycles.
- Flags:
  - clr_flags clears ovf and unf on the next edge.
  - If a new event and clr_flags occur in the same cycle, the set wins.
- Mode, limit and step may change on any cycle. They take effect at the next edge.
- Latency: one clock from inputs to out, tc and flags. at_max and at_min follow out combinationally.

Decomposition:
- Shared package/header holds:
  - mode encodings MODE_WRAP=0 and MODE_SAT=1
  - direction encodings DIR_UP=1 and DIR_DOWN=0
- One combinational sub-module, updn_next_calc, is natural. It takes (out, s, limit, up_down, sat_mode) and returns next_count, ovf_evt and unf_evt.
- The top level holds the registers, load/enable priority, tc pulse and sticky flags.

Test Plan:
- Reset mid-count: count to 5 (up, step=1), assert reset=0 between edges -> out=0, flags=0 immediately. Release -> next up edge gives out=1.
- Wrap up, WIDTH=8, limit=9, step=3, wrap mode, load 8 then one up -> out=1, tc pulse for 1 cycle, ovf=1, unf=0.
- Saturate down, limit=200, sat_mode=1, load 2, step=5, down -> out=0, tc=1, unf=1. Next down -> out=0, tc=1 again.
- Load priority and clamp, limit=50: load=1, en=1, data=80 -> out=50, tc=0, at_max=1.
- Limit shrink: out=40, limit changed to 30, en=1, up -> out=0, no tc. Repeat with down -> out=30.
- Flag set/clear race: ovf=1, clr_flags=1 in the same cycle as a new overflow -> ovf stays 1. clr_flags alone on the next cycle -> ovf=0.
